// File: rtl/osc_capture.sv
// osc_capture: ADC acquisition engine with decimation, rising-edge trigger and
// pre-trigger history; freezes one frame in a circular RAM for readback.
module osc_capture #(
  parameter int ADDR_W       = 10,
  parameter int PRE_SAMPLES  = 256,
  parameter int CLK_DIV      = 2,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        ad_data_in,
  output logic              ad_clk,
  input  logic              arm,
  input  logic [1:0]        horizontal_zoom,
  input  logic [7:0]        trig_level,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_valid,
  output logic              busy,
  output logic              auto_trig
);
  // state     | meaning
  // IDLE      | no capture, waiting for arm
  // PRETRIG   | filling pre-trigger history
  // WAIT_TRIG | writing circularly, looking for trigger or timeout
  // POST      | writing the remainder of the frame
  // DONE      | frame frozen and readable
  typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POST, DONE} state_t;

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int HALF   = CLK_DIV / 2;
  localparam int DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int POST_N = DEPTH - PRE_SAMPLES - 1;
  localparam int TMO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

  state_t            state, state_n;
  logic [DIV_W-1:0]  div_cnt;
  logic [1:0]        zoom_q, dec_cnt, dec_max;
  logic [ADDR_W-1:0] wr_ptr, start_ptr, cnt;
  logic [TMO_W-1:0]  tmo;
  logic [7:0]        prev_sample;
  logic [7:0]        ram [DEPTH];
  logic              strobe, kept, restart, we, trig_hit, tmo_hit, trig_evt;

  always_comb begin
    case (zoom_q)
      2'd0:    dec_max = 2'd0;
      2'd1:    dec_max = 2'd1;
      default: dec_max = 2'd3;
    endcase
  end

  assign busy     = (state == PRETRIG) || (state == WAIT_TRIG) || (state == POST);
  // ad_clk is about to fall on this edge: ADC output has settled
  assign strobe   = ad_clk && (div_cnt == '0);
  assign kept     = strobe && (dec_cnt == 2'd0);
  assign restart  = arm || (busy && (horizontal_zoom != zoom_q));
  assign we       = kept && busy && !restart;
  assign trig_hit = we && (state == WAIT_TRIG) &&
                    (prev_sample < trig_level) && (ad_data_in >= trig_level);
  assign tmo_hit  = we && (state == WAIT_TRIG) && !trig_hit &&
                    (AUTO_TIMEOUT != 0) && (tmo == '0);
  assign trig_evt = trig_hit || tmo_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (restart) begin
      state_n = PRETRIG;
    end else begin
      case (state)
        PRETRIG:   if (we && (cnt == '0)) state_n = WAIT_TRIG;
        WAIT_TRIG: if (trig_evt) state_n = (POST_N == 0) ? DONE : POST;
        POST:      if (we && (cnt == '0)) state_n = DONE;
        default:   state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ad_clk      <= 1'b0;
      div_cnt     <= '0;
      zoom_q      <= '0;
      dec_cnt     <= '0;
      wr_ptr      <= '0;
      start_ptr   <= '0;
      cnt         <= '0;
      tmo         <= '0;
      prev_sample <= '0;
      auto_trig   <= 1'b0;
      frame_valid <= 1'b0;
      rd_data     <= '0;
    end else begin
      if (div_cnt == '0) begin
        ad_clk  <= !ad_clk;
        div_cnt <= DIV_W'(HALF - 1);
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end

      zoom_q <= horizontal_zoom;

      if (restart)     dec_cnt <= 2'd0;
      else if (strobe) dec_cnt <= (dec_cnt >= dec_max) ? 2'd0 : dec_cnt + 2'd1;

      if (we) begin
        wr_ptr      <= wr_ptr + 1'b1;
        prev_sample <= ad_data_in;
      end

      // cnt counts down the PRETRIG fill, then the POST fill
      if (restart)                     cnt <= ADDR_W'(PRE_SAMPLES - 1);
      else if (trig_evt)               cnt <= ADDR_W'(POST_N - 1);
      else if (we && (cnt != '0))      cnt <= cnt - 1'b1;

      if (restart)
        tmo <= TMO_W'(AUTO_TIMEOUT - 1);
      else if (we && (state == WAIT_TRIG) && (tmo != '0))
        tmo <= tmo - 1'b1;

      if (trig_evt) start_ptr <= wr_ptr - ADDR_W'(PRE_SAMPLES);

      if (restart)      auto_trig <= 1'b0;
      else if (tmo_hit) auto_trig <= 1'b1;

      frame_valid <= (state_n == DONE);

      if (frame_valid) rd_data <= ram[start_ptr + rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) ram[wr_ptr] <= ad_data_in;
  end
endmodule

// File: tb/tb_osc_capture.sv
// tb_osc_capture: randomized bench for osc_capture against a frame-level model
// built from the kept-sample stream, plus hand-computed spot checks.
module tb_osc_capture;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int PRE   = 256;
  localparam int CDIV  = 2;
  localparam int H     = CDIV / 2;
  localparam int TMO   = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    ad_data_in = '0;
  logic          ad_clk;
  logic          arm = 1'b0;
  logic [1:0]    zoom = '0;
  logic [7:0]    lvl = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          frame_valid, busy, auto_trig;

  int n_chk = 0;
  int n_pass = 0;

  osc_capture #(.ADDR_W(AW), .PRE_SAMPLES(PRE), .CLK_DIV(CDIV), .AUTO_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(rst), .ad_data_in(ad_data_in), .ad_clk(ad_clk), .arm(arm),
    .horizontal_zoom(zoom), .trig_level(lvl), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_valid(frame_valid), .busy(busy), .auto_trig(auto_trig));

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int         n_edge, sc, phase, trig_idx, base, wcount, m_start;
  bit         m_ad, m_fv, m_busy, m_auto, m_strobe;
  logic [7:0] m_rd;
  logic [1:0] mzoom;
  logic [7:0] hist [$];
  logic [7:0] frame [DEPTH];

  function automatic int adf(input int n);
    return ((n + H - 1) / H) % 2;
  endfunction

  task automatic model_step();
    int fac, i;
    bit rs, keep;
    if (m_fv) m_rd = frame[rd_addr];
    n_edge++;
    m_strobe = (adf(n_edge - 1) == 1) && (adf(n_edge) == 0);
    m_ad = (adf(n_edge) == 1);
    fac = (mzoom == 2'd0) ? 1 : (mzoom == 2'd1) ? 2 : 4;
    rs = arm || (phase == 1 && zoom != mzoom);
    mzoom = zoom;
    if (rs) begin
      phase = 1; hist.delete(); trig_idx = -1; base = wcount; sc = 0; m_auto = 0;
    end else if (m_strobe) begin
      keep = (sc % fac) == 0;
      sc++;
      if (keep && phase == 1) begin
        hist.push_back(ad_data_in);
        wcount++;
        i = hist.size() - 1;
        if (trig_idx < 0 && i >= PRE) begin
          if (hist[i-1] < lvl && hist[i] >= lvl) trig_idx = i;
          else if (i - PRE + 1 == TMO) begin trig_idx = i; m_auto = 1; end
        end
        if (trig_idx >= 0 && i - trig_idx == DEPTH - PRE - 1) begin
          for (int k = 0; k < DEPTH; k++) frame[k] = hist[trig_idx - PRE + k];
          m_start = (base + trig_idx - PRE) % DEPTH;
          phase = 2;
        end
      end
    end
    m_fv = (phase == 2);
    m_busy = (phase == 1);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n_edge = 0; m_ad = 0; m_fv = 0; m_busy = 0; m_auto = 0; m_rd = '0; mzoom = '0;
      sc = 0; phase = 0; trig_idx = -1; base = 0; wcount = 0; m_start = 0; m_strobe = 0;
      hist.delete();
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("ad_clk", int'(ad_clk), int'(m_ad));
      check("frame_valid", int'(frame_valid), int'(m_fv));
      check("busy", int'(busy), int'(m_busy));
      check("auto_trig", int'(auto_trig), int'(m_auto));
      check("rd_data", int'(rd_data), int'(m_rd));
      if (m_fv) check("start_ptr", int'(dut.start_ptr), m_start);
    end
  end

  // ---------------- ADC data source ----------------
  int         mode = 0;
  logic [7:0] cval = 8'h10;
  logic [7:0] ramp = 8'd100;

  always @(negedge clk) begin
    if (m_strobe && !rst) ramp = ramp + 8'd1;
    case (mode)
      1:       ad_data_in = ramp;
      2:       ad_data_in = cval;
      default: ad_data_in = 8'($urandom);
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_arm(input logic [1:0] z);
    @(negedge clk); arm = 1'b1; zoom = z;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while (!frame_valid && c < budget) begin @(negedge clk); c++; end
    check(name, int'(frame_valid), 1);
  endtask

  task automatic read_at(input int a, output logic [7:0] v);
    @(negedge clk); rd_addr = AW'(a);
    @(negedge clk); v = rd_data;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [7:0] a, b;
    // reset state
    idle_cycles(3);
    check("rst_ad_clk", int'(ad_clk), 0);
    check("rst_frame_valid", int'(frame_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_data", int'(rd_data), 0);
    rst = 1'b0;

    // basic ramp trigger, zoom 0
    mode = 1; lvl = 8'd128; ramp = 8'd100;
    do_arm(2'd0);
    wait_done("t2_done", 20000);
    read_at(256, a); check("t2_rd256", int'(a), 128);
    read_at(255, a); check("t2_rd255", int'(a), 127);
    check("t2_auto", int'(auto_trig), 0);

    // re-arm from DONE, then abort by zoom change in WAIT_TRIG
    lvl = 8'd0;
    do_arm(2'd0);
    check("t5_fv_low", int'(frame_valid), 0);
    check("t5_busy", int'(busy), 1);
    idle_cycles(530);
    @(negedge clk); zoom = 2'd1; lvl = 8'd128;
    @(negedge clk);
    check("t5_zoom_busy", int'(busy), 1);
    idle_cycles(1000);
    check("t5_no_frame", int'(frame_valid), 0);
    wait_done("t5_done", 20000);

    // decimation by 4
    ramp = 8'd100;
    do_arm(2'd2);
    wait_done("t3_done", 30000);
    read_at(300, a); read_at(301, b); check("t3_step_a", int'(8'(b - a)), 4);
    read_at(600, a); read_at(601, b); check("t3_step_b", int'(8'(b - a)), 4);

    // auto trigger on a flat input
    mode = 2; cval = 8'h10; lvl = 8'h80;
    do_arm(2'd0);
    wait_done("t4_done", 20000);
    check("t4_auto", int'(auto_trig), 1);
    read_at(0, a);    check("t4_rd0", int'(a), 16);
    read_at(511, a);  check("t4_rd511", int'(a), 16);
    read_at(1023, a); check("t4_rd1023", int'(a), 16);

    // randomized frames with occasional aborts
    mode = 0;
    for (int r = 0; r < 4; r++) begin
      lvl = 8'($urandom_range(16, 240));
      do_arm(2'($urandom_range(0, 1)));
      if (r % 2 == 1) begin
        idle_cycles($urandom_range(50, 900));
        do_arm(zoom);
      end
      wait_done("rand_done", 30000);
      for (int i = 0; i < 64; i++) begin
        @(negedge clk); rd_addr = AW'($urandom);
      end
    end

    // reset in the middle of POST
    lvl = 8'd128;
    do_arm(2'd0);
    idle_cycles(1300);
    check("t1_busy_pre", int'(busy), 1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("t1_ad_clk", int'(ad_clk), 0);
    check("t1_rd_data", int'(rd_data), 0);
    check("t1_frame_valid", int'(frame_valid), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_auto", int'(auto_trig), 0);
    idle_cycles(3);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); check("t1_adclk_hi", int'(ad_clk), 1);
    @(negedge clk); check("t1_adclk_lo", int'(ad_clk), 0);
    idle_cycles(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
